// File: rtl/npu_job_controller_pkg.sv
// Shared types for the NPU job front-end: host-visible status codes and FSM states.
package npu_job_controller_pkg;

    typedef enum logic [1:0] {
        WAITING          = 2'd0,
        BUSY             = 2'd1,
        DONE_AND_WAITING = 2'd2
    } system_status_t;

    typedef enum logic [1:0] {
        IDLE_MEMORY = 2'd0,
        READING     = 2'd1,
        WRITING     = 2'd2
    } memory_status_t;

    typedef enum logic [1:0] {
        NO_ERROR        = 2'd0,
        INVALID_N_VALUE = 2'd1,
        OUT_OF_BOUNDS   = 2'd2,
        OVERFLOW        = 2'd3
    } error_code_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_VERIFY = 3'd2,
        S_LAUNCH = 3'd3,
        S_RUN    = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } job_state_t;

    // Host-visible status for a job state; the stepping path uses the same mapping.
    function automatic system_status_t status_of(input job_state_t s);
        system_status_t r;
        r = WAITING;
        case (s)
            S_CHECK, S_VERIFY, S_LAUNCH, S_RUN: r = BUSY;
            S_DONE:                             r = DONE_AND_WAITING;
            default:                            r = WAITING;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/npu_job_checker.sv
// Command validation pipeline: N*N and the N range check are registered in CHECK,
// the region bound test is evaluated from those registers during VERIFY.
module npu_job_checker #(
    parameter int ADDR_W    = 12,
    parameter int N_W       = 9,
    parameter int MAX_N     = 128,
    parameter int MEM_DEPTH = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              check_en,
    input  logic [N_W-1:0]    cfg_n,
    input  logic [ADDR_W-1:0] cfg_addr_a,
    input  logic [ADDR_W-1:0] cfg_addr_b,
    input  logic [ADDR_W-1:0] cfg_addr_c,
    output logic              n_bad,
    output logic              oob
);
    localparam int SQ_W  = 2 * N_W;
    // One bit wider than either operand so addr + N*N can never wrap.
    localparam int SUM_W = ((ADDR_W > SQ_W) ? ADDR_W : SQ_W) + 1;

    logic [SQ_W-1:0]  sq;
    logic [SUM_W-1:0] end_a, end_b, end_c;

    // First stage: square N and range-check it while the command sits in CHECK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sq    <= '0;
            n_bad <= 1'b0;
        end else if (check_en) begin
            sq    <= SQ_W'(cfg_n) * SQ_W'(cfg_n);
            n_bad <= (cfg_n == '0) || (cfg_n > N_W'(MAX_N));
        end
    end

    // Second stage: any region ending past the memory is out of bounds.
    always_comb begin
        end_a = {{(SUM_W-ADDR_W){1'b0}}, cfg_addr_a} + {{(SUM_W-SQ_W){1'b0}}, sq};
        end_b = {{(SUM_W-ADDR_W){1'b0}}, cfg_addr_b} + {{(SUM_W-SQ_W){1'b0}}, sq};
        end_c = {{(SUM_W-ADDR_W){1'b0}}, cfg_addr_c} + {{(SUM_W-SQ_W){1'b0}}, sq};
        oob   = (end_a > SUM_W'(MEM_DEPTH)) || (end_b > SUM_W'(MEM_DEPTH)) ||
                (end_c > SUM_W'(MEM_DEPTH));
    end

endmodule

// File: rtl/npu_job_controller.sv
// Job front-end for the systolic array: accepts, validates and launches matmul jobs,
// then tracks completion, overflow, run time and job count for the host.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   S_IDLE   | waiting for a command (cmd_ready=1)
//   S_CHECK  | N*N and N range being registered
//   S_VERIFY | region bounds evaluated, pick ERROR or LAUNCH
//   S_LAUNCH | one-cycle launch pulse to the array
//   S_RUN    | array busy, count cycles, watch done/overflow
//   S_DONE   | job finished, may accept the next command
//   S_ERROR  | sticky command error until err_clear
module npu_job_controller
    import npu_job_controller_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int N_W       = 9,
    parameter int MAX_N     = 128,
    parameter int MEM_DEPTH = 4096,
    parameter int CYC_W     = 24,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [ADDR_W-1:0] addr_c,
    input  logic [N_W-1:0]    matrix_n,
    input  logic              abort,
    input  logic              err_clear,
    input  logic              core_done,
    input  logic              core_overflow,
    input  logic              mem_rd_active,
    input  logic              mem_wr_active,
    output logic              launch,
    output logic [ADDR_W-1:0] cfg_addr_a,
    output logic [ADDR_W-1:0] cfg_addr_b,
    output logic [ADDR_W-1:0] cfg_addr_c,
    output logic [N_W-1:0]    cfg_n,
    output system_status_t    system_status,
    output memory_status_t    memory_status,
    output error_code_t       error_code,
    output logic              new_data_out,
    output logic [CYC_W-1:0]  run_cycles,
    output logic [CNT_W-1:0]  op_count
);
    job_state_t state, next_state;
    logic       accept, n_bad, oob;

    // cmd_ready is registered, so it is already low in IDLE during the reset cycle.
    assign accept       = cmd_valid && cmd_ready;
    assign new_data_out = launch;

    npu_job_checker #(
        .ADDR_W    (ADDR_W),
        .N_W       (N_W),
        .MAX_N     (MAX_N),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_checker (
        .clk        (clk),
        .rst_n      (rst_n),
        .check_en   (state == S_CHECK),
        .cfg_n      (cfg_n),
        .cfg_addr_a (cfg_addr_a),
        .cfg_addr_b (cfg_addr_b),
        .cfg_addr_c (cfg_addr_c),
        .n_bad      (n_bad),
        .oob        (oob)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    // Next-state logic; abort wins over core_done in the busy states.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (accept) next_state = S_CHECK;
            S_CHECK:  next_state = abort ? S_IDLE : S_VERIFY;
            S_VERIFY: begin
                if (abort)             next_state = S_IDLE;
                else if (n_bad || oob) next_state = S_ERROR;
                else                   next_state = S_LAUNCH;
            end
            S_LAUNCH: next_state = abort ? S_IDLE : S_RUN;
            S_RUN: begin
                if (abort)          next_state = S_IDLE;
                else if (core_done) next_state = S_DONE;
            end
            S_DONE:   if (accept) next_state = S_CHECK;
            S_ERROR:  if (err_clear) next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // Handshake, launch pulse and status registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready     <= 1'b0;
            launch        <= 1'b0;
            system_status <= WAITING;
            memory_status <= IDLE_MEMORY;
        end else begin
            cmd_ready     <= (next_state == S_IDLE) || (next_state == S_DONE);
            launch        <= (next_state == S_LAUNCH);
            system_status <= status_of(next_state);
            if (state == S_RUN && next_state == S_RUN)
                memory_status <= mem_wr_active ? WRITING :
                                 mem_rd_active ? READING : IDLE_MEMORY;
            else
                memory_status <= IDLE_MEMORY;
        end
    end

    // Command latch and error code; an accepted command starts with a clean error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_addr_a <= '0;
            cfg_addr_b <= '0;
            cfg_addr_c <= '0;
            cfg_n      <= '0;
            error_code <= NO_ERROR;
        end else if (accept) begin
            cfg_addr_a <= addr_a;
            cfg_addr_b <= addr_b;
            cfg_addr_c <= addr_c;
            cfg_n      <= matrix_n;
            error_code <= NO_ERROR;
        end else begin
            case (state)
                S_VERIFY: if (!abort) begin
                    if (n_bad)    error_code <= INVALID_N_VALUE;
                    else if (oob) error_code <= OUT_OF_BOUNDS;
                end
                S_RUN:   if (!abort && core_overflow) error_code <= OVERFLOW;
                S_DONE:  if (err_clear && error_code == OVERFLOW) error_code <= NO_ERROR;
                S_ERROR: if (err_clear) error_code <= NO_ERROR;
                default: ;
            endcase
        end
    end

    // Run-cycle counter (saturating) and completed-job counter (wrapping).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cycles <= '0;
            op_count   <= '0;
        end else begin
            if (accept)
                run_cycles <= '0;
            else if (state == S_RUN && run_cycles != '1)
                run_cycles <= run_cycles + CYC_W'(1);
            if (state == S_RUN && next_state == S_DONE)
                op_count <= op_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_npu_job_controller.sv
// Directed bench for npu_job_controller with hand-computed expectations.
module tb_npu_job_controller;
    import npu_job_controller_pkg::*;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [11:0]    addr_a = '0, addr_b = '0, addr_c = '0;
    logic [8:0]     matrix_n = '0;
    logic           abort = 1'b0, err_clear = 1'b0;
    logic           core_done = 1'b0, core_overflow = 1'b0;
    logic           mem_rd_active = 1'b0, mem_wr_active = 1'b0;
    logic           launch, new_data_out;
    logic [11:0]    cfg_addr_a, cfg_addr_b, cfg_addr_c;
    logic [8:0]     cfg_n;
    system_status_t system_status;
    memory_status_t memory_status;
    error_code_t    error_code;
    logic [23:0]    run_cycles;
    logic [15:0]    op_count;

    int checks = 0;
    int errors = 0;

    npu_job_controller dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .addr_a        (addr_a),
        .addr_b        (addr_b),
        .addr_c        (addr_c),
        .matrix_n      (matrix_n),
        .abort         (abort),
        .err_clear     (err_clear),
        .core_done     (core_done),
        .core_overflow (core_overflow),
        .mem_rd_active (mem_rd_active),
        .mem_wr_active (mem_wr_active),
        .launch        (launch),
        .cfg_addr_a    (cfg_addr_a),
        .cfg_addr_b    (cfg_addr_b),
        .cfg_addr_c    (cfg_addr_c),
        .cfg_n         (cfg_n),
        .system_status (system_status),
        .memory_status (memory_status),
        .error_code    (error_code),
        .new_data_out  (new_data_out),
        .run_cycles    (run_cycles),
        .op_count      (op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command for one edge (the accepting edge E0).
    task automatic send_cmd(input logic [11:0] a, input logic [11:0] b,
                            input logic [11:0] c, input logic [8:0] n);
        addr_a = a; addr_b = b; addr_c = c; matrix_n = n;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Command expected to pass validation: check the launch window, end in RUN.
    task automatic go_to_run(input string tag, input logic [11:0] a, input logic [11:0] b,
                             input logic [11:0] c, input logic [8:0] n);
        send_cmd(a, b, c, n);
        chk({tag, "_busy"}, system_status, BUSY);
        tick();
        chk({tag, "_nolaunch_e1"}, launch, 1'b0);
        tick();
        chk({tag, "_launch_e2"}, launch, 1'b1);
        chk({tag, "_newdata_e2"}, new_data_out, 1'b1);
        tick();
        chk({tag, "_launch_e3"}, launch, 1'b0);
    endtask

    // Command expected to be rejected: check the latched error, then clear it.
    task automatic expect_error(input string tag, input logic [11:0] a, input logic [11:0] b,
                                input logic [11:0] c, input logic [8:0] n,
                                input error_code_t code);
        send_cmd(a, b, c, n);
        tick();
        tick();
        chk({tag, "_code"}, error_code, code);
        chk({tag, "_ready"}, cmd_ready, 1'b0);
        chk({tag, "_launch"}, launch, 1'b0);
        chk({tag, "_status"}, system_status, WAITING);
        tick();
        chk({tag, "_held"}, error_code, code);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk({tag, "_cleared"}, error_code, NO_ERROR);
        chk({tag, "_ready_after"}, cmd_ready, 1'b1);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_ready", cmd_ready, 1'b0);
        chk("rst_status", system_status, WAITING);
        chk("rst_err", error_code, NO_ERROR);
        chk("rst_ops", op_count, 16'd0);
        tick();
        rst_n = 1'b1;
        chk("rel_ready_before_edge", cmd_ready, 1'b0);
        tick();
        chk("rel_ready", cmd_ready, 1'b1);

        // Valid job N=4, done on the 10th RUN cycle
        go_to_run("job1", 12'd0, 12'd16, 12'd32, 9'd4);
        chk("job1_cfg_n", cfg_n, 9'd4);
        chk("job1_cfg_b", cfg_addr_b, 12'd16);
        chk("job1_cfg_c", cfg_addr_c, 12'd32);
        repeat (9) tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("job1_status", system_status, DONE_AND_WAITING);
        chk("job1_err", error_code, NO_ERROR);
        chk("job1_ops", op_count, 16'd1);
        chk("job1_cycles", run_cycles, 24'd10);
        chk("job1_ready", cmd_ready, 1'b1);

        // Invalid N, and N priority over bounds
        expect_error("n0", 12'd0, 12'd0, 12'd0, 9'd0, INVALID_N_VALUE);
        expect_error("n129", 12'd0, 12'd0, 12'd0, 9'd129, INVALID_N_VALUE);
        expect_error("n129_a4090", 12'd4090, 12'd0, 12'd0, 9'd129, INVALID_N_VALUE);

        // Bounds edge: 4080+16 = 4096 fits
        go_to_run("a4080", 12'd4080, 12'd0, 12'd0, 9'd4);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("a4080_ops", op_count, 16'd2);
        expect_error("a4081", 12'd4081, 12'd0, 12'd0, 9'd4, OUT_OF_BOUNDS);

        // C=4095, N=1 fits; also exercises memory status
        go_to_run("c4095", 12'd0, 12'd0, 12'd4095, 9'd1);
        chk("mem_idle_start", memory_status, IDLE_MEMORY);
        mem_rd_active = 1'b1;
        tick();
        chk("mem_reading", memory_status, READING);
        mem_wr_active = 1'b1;
        tick();
        chk("mem_writing", memory_status, WRITING);
        mem_wr_active = 1'b0;
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("mem_idle_done", memory_status, IDLE_MEMORY);
        chk("c4095_ops", op_count, 16'd3);
        chk("c4095_cycles", run_cycles, 24'd3);
        tick();
        chk("mem_idle_outside", memory_status, IDLE_MEMORY);
        mem_rd_active = 1'b0;

        // Overflow then done 3 cycles later
        go_to_run("ovf", 12'd0, 12'd0, 12'd0, 9'd2);
        core_overflow = 1'b1;
        tick();
        core_overflow = 1'b0;
        chk("ovf_latched", error_code, OVERFLOW);
        chk("ovf_busy", system_status, BUSY);
        tick();
        tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("ovf_done_status", system_status, DONE_AND_WAITING);
        chk("ovf_done_err", error_code, OVERFLOW);
        chk("ovf_ops", op_count, 16'd4);
        chk("ovf_ready", cmd_ready, 1'b1);

        // New command from DONE clears OVERFLOW; done and overflow together
        send_cmd(12'd8, 12'd8, 12'd8, 9'd3);
        chk("redo_err_clear", error_code, NO_ERROR);
        chk("redo_cycles_clear", run_cycles, 24'd0);
        tick();
        tick();
        chk("redo_launch", launch, 1'b1);
        tick();
        core_done = 1'b1;
        core_overflow = 1'b1;
        tick();
        core_done = 1'b0;
        core_overflow = 1'b0;
        chk("both_status", system_status, DONE_AND_WAITING);
        chk("both_err", error_code, OVERFLOW);
        chk("both_ops", op_count, 16'd5);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("done_clear_err", error_code, NO_ERROR);
        chk("done_clear_status", system_status, DONE_AND_WAITING);

        // Abort beats core_done in RUN
        go_to_run("abort", 12'd0, 12'd0, 12'd0, 9'd2);
        tick();
        abort = 1'b1;
        core_done = 1'b1;
        tick();
        abort = 1'b0;
        core_done = 1'b0;
        chk("abort_status", system_status, WAITING);
        chk("abort_ops", op_count, 16'd5);
        chk("abort_err", error_code, NO_ERROR);
        chk("abort_ready", cmd_ready, 1'b1);

        // Asynchronous reset mid-RUN
        go_to_run("rstrun", 12'd100, 12'd200, 12'd300, 9'd5);
        tick();
        tick();
        rst_n = 1'b0;
        #2;
        chk("arst_ready", cmd_ready, 1'b0);
        chk("arst_status", system_status, WAITING);
        chk("arst_ops", op_count, 16'd0);
        chk("arst_cycles", run_cycles, 24'd0);
        chk("arst_cfg_a", cfg_addr_a, 12'd0);
        chk("arst_cfg_n", cfg_n, 9'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_ready_after", cmd_ready, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
